// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one execute-stage ALU between the pipeline (port 0) and
// the pixel unit (port 1): registers the winner's operands, holds them, returns the result.
module alu_share_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [3:0]       rsp0_flags,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [3:0]       rsp1_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags
);

  localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_L + 1) + 1;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nx;
  logic             last_grant;
  logic             gnt;
  logic             div0;
  logic [CW-1:0]    cnt;

  logic             win;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;
  logic             sel_div0;
  logic [CW-1:0]    sel_lat;

  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) win = ~last_grant;
    else if (req1_valid)          win = 1'b1;

    accept   = (state == IDLE) && (req0_valid || req1_valid);
    sel_a    = win ? req1_a  : req0_a;
    sel_b    = win ? req1_b  : req0_b;
    sel_op   = win ? req1_op : req0_op;
    sel_div0 = (sel_op == OP_DIV) && (sel_b == '0);

    if (sel_div0)              sel_lat = CW'(1);
    else if (sel_op == OP_MUL) sel_lat = CW'(MUL_CYCLES);
    else if (sel_op == OP_DIV) sel_lat = CW'(DIV_CYCLES);
    else                       sel_lat = CW'(1);

    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // ready is masked by rst_n so it reads low for the whole reset interval
    req0_ready = rst_n && accept && !win;
    req1_ready = rst_n && accept && win;
    rsp0_valid = (state == RESP) && !gnt;
    rsp1_valid = (state == RESP) && gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      div0        <= 1'b0;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= 4'b0000;
      rsp0_result <= '0;
      rsp0_flags  <= '0;
      rsp1_result <= '0;
      rsp1_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            alu_control <= sel_op;
            last_grant  <= win;
            gnt         <= win;
            div0        <= sel_div0;
            // Loaded with L (not L-1): the extra EXEC cycle places the capture
            // edge at accept+L+1, so the strobe spans accept+L+1..accept+L+2.
            cnt         <= sel_lat;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            if (!gnt) begin
              rsp0_result <= div0 ? '1 : alu_result;
              rsp0_flags  <= div0 ? 4'b0000 : alu_flags;
            end else begin
              rsp1_result <= div0 ? '1 : alu_result;
              rsp1_flags  <= div0 ? 4'b0000 : alu_flags;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
